// File: rtl/cva6_axi_isolate_ctrl.sv
// Outstanding-transaction limiter and AW/AR isolation gate for the CVA6 AXI master port.
// Optional drain timeout is built when CVA6_ISOLATE_TIMEOUT_EN is defined.
module cva6_axi_isolate_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic isolate_req_i,
   output logic isolated_o,
   output logic busy_o,
   output logic timeout_o,
   output logic protocol_err_o,
   input  logic mst_aw_valid_i,
   output logic mst_aw_ready_o,
   output logic slv_aw_valid_o,
   input  logic slv_aw_ready_i,
   input  logic mst_ar_valid_i,
   output logic mst_ar_ready_o,
   output logic slv_ar_valid_o,
   input  logic slv_ar_ready_i,
   input  logic b_valid_i,
   input  logic b_ready_i,
   input  logic r_valid_i,
   input  logic r_ready_i,
   input  logic r_last_i
);

   localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("cva6_axi_isolate_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic                 perr_q, perr_d;
   logic                 gate_aw, gate_ar;
   logic                 aw_acc, ar_acc, b_done, r_done;

   // Pass-through: gating depends only on registered state, so no handshake breaks mid-cycle
   assign slv_aw_valid_o = mst_aw_valid_i & ~gate_aw;
   assign mst_aw_ready_o = slv_aw_ready_i & ~gate_aw;
   assign slv_ar_valid_o = mst_ar_valid_i & ~gate_ar;
   assign mst_ar_ready_o = slv_ar_ready_i & ~gate_ar;

   assign aw_acc = slv_aw_valid_o & slv_aw_ready_i;
   assign ar_acc = slv_ar_valid_o & slv_ar_ready_i;
   assign b_done = b_valid_i & b_ready_i;
   assign r_done = r_valid_i & r_ready_i & r_last_i;

   assign busy_o         = (wr_cnt_q != '0) | (rd_cnt_q != '0);
   assign isolated_o     = (state_q == ISOLATED);
   assign protocol_err_o = perr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin : fsm_reg
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      gate_aw = 1'b1;
      gate_ar = 1'b1;
      case (state_q)
         RUN: begin
            gate_aw = (wr_cnt_q == CNT_MAX);
            gate_ar = (rd_cnt_q == CNT_MAX);
            if (isolate_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!isolate_req_i) begin
               state_d = RUN;
            end else if (wr_cnt_q == '0 && rd_cnt_q == '0) begin
               state_d = ISOLATED;
            end
         end
         ISOLATED: begin
            if (!isolate_req_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Simultaneous issue and completion cancel; completions at zero are clamped and flagged
   always_comb begin : cnt_next
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (aw_acc && !b_done) begin
         wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
      end else if (!aw_acc && b_done && wr_cnt_q != '0) begin
         wr_cnt_d = wr_cnt_q - CNT_WIDTH'(1);
      end
      if (ar_acc && !r_done) begin
         rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
      end else if (!ar_acc && r_done && rd_cnt_q != '0) begin
         rd_cnt_d = rd_cnt_q - CNT_WIDTH'(1);
      end
      perr_d = perr_q | (b_done & (wr_cnt_q == '0)) | (r_done & (rd_cnt_q == '0));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin : cnt_reg
      if (!rst_ni) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         perr_q   <= perr_d;
      end
   end

`ifdef CVA6_ISOLATE_TIMEOUT_EN
   localparam int unsigned DRAIN_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [DRAIN_WIDTH-1:0] drain_cnt_q;
   logic                   timeout_q;

   // Counts DRAIN cycles, saturating; cleared whenever the FSM is outside DRAIN
   always_ff @(posedge clk_i or negedge rst_ni) begin : drain_timer
      if (!rst_ni) begin
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         if (state_q == DRAIN && state_d == DRAIN) begin
            if (drain_cnt_q != DRAIN_WIDTH'(TIMEOUT_CYCLES)) begin
               drain_cnt_q <= drain_cnt_q + DRAIN_WIDTH'(1);
            end
         end else begin
            drain_cnt_q <= '0;
         end
         if (state_q == DRAIN && drain_cnt_q == DRAIN_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule
